// File: rtl/rf_wr_arbiter_if.sv
// Register-file write-back bus: requester handshake plus the shared write port
// and pending-write mask returned to the hazard unit.
interface rf_wr_arbiter_if #(parameter int N_REQ = 3);
  logic                  hold;
  logic [N_REQ-1:0]      req_valid;
  logic [5*N_REQ-1:0]    req_addr;
  logic [32*N_REQ-1:0]   req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  wE;
  logic [4:0]            wR;
  logic [31:0]           dataW;
  logic [31:0]           pend_mask;
  logic [2:0]            grant_id;

  modport master (
    output hold, req_valid, req_addr, req_data,
    input  req_ready, wE, wR, dataW, pend_mask, grant_id
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data,
    output req_ready, wE, wR, dataW, pend_mask, grant_id
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ sources.
// Define RF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead.
module rf_wr_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic           clk,
  input  logic           rst,
  rf_wr_arbiter_if.slave bus
);

  logic [N_REQ-1:0] w_ready;
  logic             w_accept;
  logic [2:0]       w_win;
  logic [4:0]       w_addr;
  logic [31:0]      w_data;
  logic [31:0]      w_pend;
  int               w_idx;

  logic             r_we;
  logic [4:0]       r_wr;
  logic [31:0]      r_data;
  logic [2:0]       r_gid;
`ifndef RF_ARB_FIXED_PRIO_EN
  logic [2:0]       r_last;
`endif

  // Scan from lowest to highest priority so the highest-priority valid wins.
  always_comb begin
    w_accept = 1'b0;
    w_win    = '0;
    w_addr   = '0;
    w_data   = '0;
    w_idx    = 0;
    if (!bus.hold) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (bus.req_valid[i]) begin
          w_accept = 1'b1;
          w_win    = i[2:0];
          w_addr   = bus.req_addr[5*i +: 5];
          w_data   = bus.req_data[32*i +: 32];
        end
      end
`else
      for (int k = N_REQ; k >= 1; k--) begin
        w_idx = (int'(r_last) + k) % N_REQ;
        if (bus.req_valid[w_idx]) begin
          w_accept = 1'b1;
          w_win    = w_idx[2:0];
          w_addr   = bus.req_addr[5*w_idx +: 5];
          w_data   = bus.req_data[32*w_idx +: 32];
        end
      end
`endif
    end
  end

  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_ready[i] = w_accept && (w_win == i[2:0]);
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i]) w_pend[bus.req_addr[5*i +: 5]] = 1'b1;
    end
    if (r_we) w_pend[r_wr] = 1'b1;
    w_pend[0] = 1'b0;
  end

  // r0 writes are accepted and advance the pointer but never raise wE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= 1'b0;
      r_wr   <= '0;
      r_data <= '0;
      r_gid  <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
      r_last <= 3'(N_REQ - 1);
`endif
    end else begin
      r_we <= w_accept && (w_addr != 5'd0);
      if (w_accept) begin
        r_wr   <= w_addr;
        r_data <= w_data;
        r_gid  <= w_win;
`ifndef RF_ARB_FIXED_PRIO_EN
        r_last <= w_win;
`endif
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.pend_mask = w_pend;
  assign bus.wE        = r_we;
  assign bus.wR        = r_wr;
  assign bus.dataW     = r_data;
  assign bus.grant_id  = r_gid;

endmodule
